// File: rtl/rgb_byte_writer_pkg.sv
// Shared types and frame-size helpers for the RGB byte writer.
package rgb_byte_writer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT_R = 2'd1,
        EMIT_G = 2'd2,
        EMIT_B = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    function automatic int unsigned frame_pixels(input int unsigned cols, input int unsigned rows);
        return cols * rows;
    endfunction

    function automatic int unsigned frame_bytes(input int unsigned cols, input int unsigned rows);
        return 3 * frame_pixels(cols, rows);
    endfunction

endpackage

// File: rtl/rgb_byte_writer_fifo.sv
// Show-ahead pixel FIFO; a flush coincident with a push leaves exactly that pixel queued.
module pixel_fifo
    import rgb_byte_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   push,
    input  logic   pop,
    input  pixel_t wdata,
    output pixel_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    pixel_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[flush ? '0 : wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/rgb_byte_writer.sv
// Serializes 24-bit pixels into R, G, B byte writes at consecutive BRAM addresses.
//   state  | meaning
//   IDLE   | no byte being written
//   EMIT_R | writing red byte of the popped pixel
//   EMIT_G | writing green byte
//   EMIT_B | writing blue byte, next pixel may be popped
module rgb_byte_writer
    import rgb_byte_writer_pkg::*;
#(
    parameter int ACTIVE_COLS = 320,
    parameter int ACTIVE_ROWS = 180,
    parameter int ADDR_W      = 22,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din,
    output logic              frame_done,
    output logic              busy,
    output logic              overflow,
    output logic [15:0]       pixel_count
);

    localparam int unsigned      FRAME_BYTES = frame_bytes(ACTIVE_COLS, ACTIVE_ROWS);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_BYTES - 1);

    state_t            state, next_state;
    pixel_t            head;
    logic              full, empty;
    logic              push, pop, flush, done_now, overflow_set;
    logic              frame_full;
    logic [15:0]       gb_hold;
    logic [ADDR_W-1:0] next_addr;

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (pclk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ('{r: pix_r, g: pix_g, b: pix_b}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        done_now   = 1'b0;
        if (frame_start) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty && !frame_full) begin
                        next_state = EMIT_R;
                        pop        = 1'b1;
                    end
                end
                EMIT_R: next_state = EMIT_G;
                EMIT_G: next_state = EMIT_B;
                EMIT_B: begin
                    if (bram_addr == LAST_ADDR) begin
                        done_now   = 1'b1;
                        next_state = IDLE;
                    end else if (!empty) begin
                        next_state = EMIT_R;
                        pop        = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Pixels still queued when the frame fills are discarded with the flush.
    assign flush        = frame_start || done_now;
    assign push         = pix_valid && (frame_start || (!full && !frame_full && !done_now));
    assign overflow_set = pix_valid && !frame_start && full && !frame_full && !done_now;
    assign busy         = !empty || (state != IDLE);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            bram_din    <= '0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            pixel_count <= '0;
            frame_full  <= 1'b0;
            next_addr   <= '0;
            gb_hold     <= '0;
        end else if (frame_start) begin
            bram_we     <= 1'b0;
            bram_addr   <= '0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            pixel_count <= '0;
            frame_full  <= 1'b0;
            next_addr   <= '0;
        end else begin
            frame_done <= done_now;
            if (done_now)     frame_full <= 1'b1;
            if (overflow_set) overflow   <= 1'b1;
            bram_we <= (next_state != IDLE);
            if (pop) gb_hold <= {head.g, head.b};
            case (next_state)
                EMIT_R:  bram_din <= head.r;
                EMIT_G:  bram_din <= gb_hold[15:8];
                EMIT_B:  bram_din <= gb_hold[7:0];
                default: bram_din <= bram_din;
            endcase
            if (next_state != IDLE) begin
                bram_addr <= next_addr;
                if (next_addr != LAST_ADDR) next_addr <= next_addr + ADDR_W'(1);
            end
            if (next_state == EMIT_B) pixel_count <= pixel_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_rgb_byte_writer.sv
// Randomized and directed bench for rgb_byte_writer on a 4x2 frame (24 bytes).
module tb_rgb_byte_writer;

    localparam int COLS      = 4;
    localparam int ROWS      = 2;
    localparam int AW        = 22;
    localparam int DEPTH     = 4;
    localparam int FRAME_PIX = COLS * ROWS;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [7:0]    pix_r = '0, pix_g = '0, pix_b = '0;
    logic          bram_we, frame_done, busy, overflow;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_din;
    logic [15:0]   pixel_count;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    wr_t         got[$];
    int          done_cyc[$];
    bit          busy_log[int];
    logic [23:0] pix_q[$];
    int          gap_q[$];
    int          tv_q[$];

    rgb_byte_writer #(
        .ACTIVE_COLS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_din(bram_din), .frame_done(frame_done),
        .busy(busy), .overflow(overflow), .pixel_count(pixel_count)
    );

    initial forever #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (rst_n) begin
            if (bram_we)    got.push_back('{32'(cyc), bram_addr, bram_din});
            if (frame_done) done_cyc.push_back(cyc);
            busy_log[cyc] = busy;
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        got.delete();
        done_cyc.delete();
    endtask

    task automatic play();
        tv_q.delete();
        for (int k = 0; k < pix_q.size(); k++) begin
            repeat (gap_q[k]) tick();
            pix_valid = 1'b1;
            {pix_r, pix_g, pix_b} = pix_q[k];
            tv_q.push_back(cyc);
            tick();
            pix_valid = 1'b0;
        end
        repeat (25) tick();
    endtask

    // Reference: each accepted pixel starts its R byte at max(arrival+2, previous R+3);
    // it occupies the FIFO from arrival+1 until the cycle before its R byte.
    task automatic check_stream(input string name);
        wr_t exp[$];
        int  rstart[$];
        int  acc = 0;
        int  last_w = -100;
        bit  exp_ovf = 1'b0;
        int  exp_done = -1;
        for (int k = 0; k < tv_q.size(); k++) begin
            int t;
            int occ;
            int wk;
            t   = tv_q[k];
            occ = 0;
            foreach (rstart[j]) if (rstart[j] > t) occ++;
            if (acc >= FRAME_PIX) continue;
            if (occ >= DEPTH) begin
                exp_ovf = 1'b1;
                continue;
            end
            wk = (t + 2 > last_w + 3) ? t + 2 : last_w + 3;
            rstart.push_back(wk);
            last_w = wk;
            exp.push_back('{32'(wk),     AW'(3*acc),     pix_q[k][23:16]});
            exp.push_back('{32'(wk + 1), AW'(3*acc + 1), pix_q[k][15:8]});
            exp.push_back('{32'(wk + 2), AW'(3*acc + 2), pix_q[k][7:0]});
            acc++;
            if (acc == FRAME_PIX) exp_done = wk + 3;
        end
        n_tests++;
        if (got.size() !== exp.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d, want %0d", name, got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL %s write[%0d]: got cyc=%0d addr=%0d data=%h, want cyc=%0d addr=%0d data=%h",
                         name, i, got[i].cyc, got[i].addr, got[i].data, exp[i].cyc, exp[i].addr, exp[i].data);
            end
        end
        n_tests++;
        if (overflow !== exp_ovf) begin
            n_fail++;
            $display("FAIL %s overflow: got %b, want %b", name, overflow, exp_ovf);
        end
        n_tests++;
        if (pixel_count !== 16'(acc)) begin
            n_fail++;
            $display("FAIL %s pixel_count: got %0d, want %0d", name, pixel_count, acc);
        end
        n_tests++;
        if (exp_done < 0 ? done_cyc.size() != 0
                         : (done_cyc.size() != 1 || done_cyc[0] != exp_done)) begin
            n_fail++;
            $display("FAIL %s frame_done: got %0d pulses (first at %0d), want at %0d",
                     name, done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, exp_done);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_idle: got %b, want 0", name, busy);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        n_tests++;
        if ({bram_we, bram_addr, bram_din, frame_done, busy, overflow, pixel_count} !== '0) begin
            n_fail++;
            $display("FAIL %s outputs: got we=%b addr=%0d din=%h done=%b busy=%b ovf=%b cnt=%0d, want all 0",
                     name, bram_we, bram_addr, bram_din, frame_done, busy, overflow, pixel_count);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (3) tick();
        check_zero_outputs("reset_hold");
        @(negedge pclk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int t;
        start_frame();
        pix_q = '{24'h112233};
        gap_q = '{0};
        play();
        check_stream("single");
        t = tv_q[0];
        n_tests++;
        if (busy_log[t+4] !== 1'b1 || busy_log[t+5] !== 1'b0) begin
            n_fail++;
            $display("FAIL single busy: got t+4=%b t+5=%b, want 1 then 0", busy_log[t+4], busy_log[t+5]);
        end
    endtask

    task automatic test_max_rate();
        start_frame();
        pix_q.delete();
        gap_q.delete();
        for (int k = 0; k < 8; k++) begin
            pix_q.push_back(24'($urandom));
            gap_q.push_back(k == 0 ? 0 : 2);
        end
        play();
        check_stream("max_rate");
    endtask

    task automatic test_overflow();
        start_frame();
        pix_q.delete();
        gap_q.delete();
        for (int k = 0; k < 8; k++) begin
            pix_q.push_back(24'($urandom));
            gap_q.push_back(0);
        end
        play();
        check_stream("overflow");
        start_frame();
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: got %b, want 0", overflow);
        end
    endtask

    task automatic test_full_frame();
        start_frame();
        pix_q.delete();
        gap_q.delete();
        for (int k = 0; k < 9; k++) begin
            pix_q.push_back(24'($urandom));
            gap_q.push_back(k == 0 ? 0 : (k == 8 ? 12 : 3));
        end
        play();
        check_stream("full_frame");
    endtask

    task automatic test_mid_pixel();
        int  t0;
        wr_t exp[5];
        start_frame();
        pix_valid = 1'b1;
        {pix_r, pix_g, pix_b} = 24'h445566;
        t0 = cyc;
        tick();
        pix_valid = 1'b0;
        repeat (2) tick();
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        {pix_r, pix_g, pix_b} = 24'hAABBCC;
        tick();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        repeat (15) tick();
        exp[0] = '{32'(t0 + 2), AW'(0), 8'h44};
        exp[1] = '{32'(t0 + 3), AW'(1), 8'h55};
        exp[2] = '{32'(t0 + 5), AW'(0), 8'hAA};
        exp[3] = '{32'(t0 + 6), AW'(1), 8'hBB};
        exp[4] = '{32'(t0 + 7), AW'(2), 8'hCC};
        n_tests++;
        if (got.size() != 5) begin
            n_fail++;
            $display("FAIL mid_pixel write_count: got %0d, want 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL mid_pixel write[%0d]: got cyc=%0d addr=%0d data=%h, want cyc=%0d addr=%0d data=%h",
                         i, got[i].cyc, got[i].addr, got[i].data, exp[i].cyc, exp[i].addr, exp[i].data);
            end
        end
        n_tests++;
        if (pixel_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_pixel pixel_count: got %0d, want 1", pixel_count);
        end
    endtask

    task automatic test_async_reset();
        start_frame();
        pix_valid = 1'b1;
        {pix_r, pix_g, pix_b} = 24'h778899;
        tick();
        pix_valid = 1'b0;
        repeat (2) tick();
        @(negedge pclk);
        n_tests++;
        if (bram_we !== 1'b1 || bram_din !== 8'h88) begin
            n_fail++;
            $display("FAIL async_pre: got we=%b din=%h, want 1 88", bram_we, bram_din);
        end
        #1 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        @(negedge pclk);
        rst_n = 1'b1;
        got.delete();
        repeat (10) tick();
        n_tests++;
        if (got.size() != 0) begin
            n_fail++;
            $display("FAIL async_release writes: got %0d, want 0", got.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int n;
            start_frame();
            pix_q.delete();
            gap_q.delete();
            n = $urandom_range(1, FRAME_PIX);
            for (int k = 0; k < n; k++) begin
                pix_q.push_back(24'($urandom));
                gap_q.push_back($urandom_range(0, 4));
            end
            play();
            check_stream("random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_rate();
        test_overflow();
        test_full_frame();
        test_mid_pixel();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
